// File: rtl/spi_peri_master.sv
// Mode-0 SPI master: one selectable active-low chip select, MSB-first, half-period of div+1 clocks.
// Defining SPI_RX_EN adds the p_miso input and the data_out capture register.
module spi_peri_master #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CS_N   = 4,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [2:0]        cs_sel,
   input  logic [DIV_W-1:0]  div,
   output logic              busy,
   output logic              done,
   output logic              p_clock,
   output logic              p_data,
   output logic [CS_N-1:0]   p_cs
`ifdef SPI_RX_EN
   ,
   input  logic              p_miso,
   output logic [DATA_W-1:0] data_out
`endif
);

   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        cs_q, cs_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              hi_q, hi_d;
   logic              busy_d, done_d, p_clock_d;
   logic [CS_N-1:0]   p_cs_d;
   logic              half_end;
   logic              cs_ok;
   logic              rise;

   assign half_end = (cnt_q == div_q);
   assign cs_ok    = ({1'b0, cs_sel} < 4'(CS_N));
   assign p_data   = sh_q[DATA_W-1];

   // State register and registered pin outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         cs_q    <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         hi_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         p_clock <= 1'b0;
         p_cs    <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         cs_q    <= cs_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         hi_q    <= hi_d;
         busy    <= busy_d;
         done    <= done_d;
         p_clock <= p_clock_d;
         p_cs    <= p_cs_d;
      end
   end

   // Next-state logic; pin outputs are derived from next-state values so they align with the state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      cs_d    = cs_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      hi_d    = hi_q;
      rise    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && cs_ok) begin
               state_d = SETUP;
               cnt_d   = '0;
               div_d   = div;
               cs_d    = cs_sel;
               sh_d    = data_in;
               bit_d   = '0;
               hi_d    = 1'b0;
            end
         end
         SETUP: begin
            if (half_end) begin
               state_d = SHIFT;
               cnt_d   = '0;
               hi_d    = 1'b1;
               rise    = 1'b1;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         SHIFT: begin
            if (half_end) begin
               cnt_d = '0;
               if (hi_q) begin
                  // falling edge: present the next bit
                  hi_d = 1'b0;
                  sh_d = sh_q << 1;
               end else if (bit_q == LAST_BIT) begin
                  state_d = HOLD;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
                  hi_d  = 1'b1;
                  rise  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         HOLD: begin
            if (half_end) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d != IDLE);
      p_clock_d = (state_d == SHIFT) && hi_d;
      done_d    = (state_d == HOLD) && (cnt_d == div_d);
      p_cs_d    = busy_d ? ~(CS_N'(1) << cs_d) : '1;
   end

`ifdef SPI_RX_EN
   logic [DATA_W-1:0] rx_q, rx_d, data_out_d;

   // p_miso is captured as p_clock rises; the word is published on the done clock
   always_comb begin
      rx_d       = rx_q;
      if (rise) begin
         rx_d = (rx_q << 1) | DATA_W'(p_miso);
      end
      data_out_d = done_d ? rx_d : data_out;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_q     <= '0;
         data_out <= '0;
      end else begin
         rx_q     <= rx_d;
         data_out <= data_out_d;
      end
   end
`endif

endmodule

// File: tb/tb_spi_peri_master.sv
// Scoreboard bench for spi_peri_master: stimulus queues expected transfers, a monitor checks each one at done.
module tb_spi_peri_master;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CS_N   = 4;
   localparam int unsigned DIV_W  = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [2:0]        cs_sel = '0;
   logic [DIV_W-1:0]  div = '0;
   logic              busy, done, p_clock, p_data;
   logic [CS_N-1:0]   p_cs;
`ifdef SPI_RX_EN
   logic [DATA_W-1:0] data_out;
`endif

   spi_peri_master #(.DATA_W(DATA_W), .CS_N(CS_N), .DIV_W(DIV_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .data_in (data_in),
      .cs_sel  (cs_sel),
      .div     (div),
      .busy    (busy),
      .done    (done),
      .p_clock (p_clock),
      .p_data  (p_data),
      .p_cs    (p_cs)
`ifdef SPI_RX_EN
      ,
      .p_miso  (p_data),
      .data_out(data_out)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  pcs;
      int          h;
      int          len;
      int          gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic xfer(input logic [15:0] d, input logic [2:0] cs, input logic [7:0] dv,
                       input logic [3:0] pcs, input int len);
      bit ok;
      @(posedge clock); #1;
      data_in = d; cs_sel = cs; div = dv; start = 1'b1;
      sb.push_back('{d, pcs, int'(dv) + 1, len, 0});
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(len + 10, ok);
      chk("done_in_time", 32'(ok), 32'd1);
      repeat (3) @(posedge clock);
   endtask

   // Monitor: measures every transfer and compares against the head of the scoreboard at done
   initial begin
      int   cyc, last_done, len, rises, hi_cnt, first_rise, last_rise;
      bit   active, cur_ok, pcs_bad, space_bad, prev_clk;
      logic [15:0] rx;
      exp_t cur;
      cyc = 0; last_done = -100; active = 0; cur_ok = 0;
      len = 0; rises = 0; hi_cnt = 0; first_rise = 0; last_rise = -1;
      pcs_bad = 0; space_bad = 0; prev_clk = 0; rx = '0;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            active = 0;
         end else begin
            if (busy && !active) begin
               active = 1; len = 0; rises = 0; hi_cnt = 0; first_rise = 0; last_rise = -1;
               pcs_bad = 0; space_bad = 0; prev_clk = 0; rx = '0;
               cur_ok = (sb.size() > 0);
               if (!cur_ok) begin
                  total++; bad++;
                  $display("FAIL unexpected_start: busy rose with no queued transfer at cycle %0d", cyc);
               end else begin
                  cur = sb[0];
                  if (cur.gap != 0) chk("restart_gap", 32'(cyc - last_done), 32'(cur.gap));
               end
            end
            if (active) begin
               len++;
               if (cur_ok && p_cs !== cur.pcs) pcs_bad = 1;
               if (p_clock) hi_cnt++;
               if (p_clock && !prev_clk) begin
                  rx = {rx[14:0], p_data};
                  rises++;
                  if (last_rise < 0) first_rise = len;
                  else if (cur_ok && (cyc - last_rise) != 2 * cur.h) space_bad = 1;
                  last_rise = cyc;
               end
               prev_clk = p_clock;
               if (done) begin
                  if (cur_ok) begin
                     void'(sb.pop_front());
                     chk("tx_data", 32'(rx), 32'(cur.data));
                     chk("p_cs_steady", 32'(pcs_bad), 32'd0);
                     chk("length", 32'(len), 32'(cur.len));
                     chk("rise_count", 32'(rises), 32'd16);
                     chk("rise_spacing", 32'(space_bad), 32'd0);
                     chk("first_rise", 32'(first_rise), 32'(cur.h + 1));
                     chk("high_cycles", 32'(hi_cnt), 32'(16 * cur.h));
                     chk("p_clock_at_done", 32'(p_clock), 32'd0);
`ifdef SPI_RX_EN
                     chk("data_out", 32'(data_out), 32'(cur.data));
`endif
                  end
                  active = 0;
                  last_done = cyc;
               end
            end else if (done) begin
               total++; bad++;
               $display("FAIL unexpected_done: done high outside a transfer at cycle %0d", cyc);
            end
         end
      end
   end

   // Stimulus
   initial begin
      bit ok;
      bit flag;
      int n;
      logic [2:0] bad_cs [2];

      repeat (3) @(negedge clock);
      chk("rst_p_cs", 32'(p_cs), 32'hF);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_p_clock", 32'(p_clock), 32'd0);
      chk("rst_p_data", 32'(p_data), 32'd0);
      chk("idle_p_cs", 32'(p_cs), 32'hF);

      xfer(16'hA5C3, 3'd2, 8'd0,   4'b1011, 34);
      xfer(16'h8001, 3'd0, 8'd3,   4'b1110, 136);
      xfer(16'h5A3C, 3'd3, 8'd1,   4'b0111, 68);
      xfer(16'hFFFF, 3'd1, 8'd0,   4'b1101, 34);
      xfer(16'h0001, 3'd1, 8'd2,   4'b1101, 102);
      xfer(16'h1357, 3'd0, 8'hFF,  4'b1110, 8704);
`ifdef SPI_RX_EN
      xfer(16'h1234, 3'd2, 8'd0,   4'b1011, 34);
`endif

      // start held high: two back-to-back transfers; div changed mid-transfer
      @(posedge clock); #1;
      data_in = 16'h3C5A; cs_sel = 3'd2; div = 8'd0; start = 1'b1;
      sb.push_back('{16'h3C5A, 4'b1011, 1, 34, 0});
      sb.push_back('{16'hC001, 4'b0111, 8, 272, 2});
      @(posedge clock); #1;
      data_in = 16'hC001; cs_sel = 3'd3; div = 8'd7;
      wait_done(50, ok);
      chk("b2b_first_done", 32'(ok), 32'd1);
      wait_done(300, ok);
      start = 1'b0;
      chk("b2b_second_done", 32'(ok), 32'd1);
      repeat (4) @(posedge clock);

      // out-of-range chip selects are ignored
      bad_cs[0] = 3'd5;
      bad_cs[1] = 3'd4;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         data_in = 16'hFFFF; cs_sel = bad_cs[k]; div = 8'd0; start = 1'b1;
         @(posedge clock); #1;
         start = 1'b0;
         flag = 0;
         repeat (10) begin
            @(negedge clock);
            if (busy || done || p_cs !== 4'hF) flag = 1;
         end
         chk("bad_cs_ignored", 32'(flag), 32'd0);
      end

      // reset in the middle of bit 7 aborts the transfer
      @(posedge clock); #1;
      data_in = 16'hA5C3; cs_sel = 3'd2; div = 8'd0; start = 1'b1;
      sb.push_back('{16'hA5C3, 4'b1011, 1, 34, 0});
      @(posedge clock); #1;
      start = 1'b0;
      n = 0;
      flag = 0;
      for (int i = 0; i < 100 && n < 8; i++) begin
         @(negedge clock);
         if (p_clock && !flag) n++;
         flag = p_clock;
      end
      chk("reached_bit7", 32'(n), 32'd8);
      #1 reset = 1'b1;
      sb.delete();
      #1;
      chk("abort_p_cs", 32'(p_cs), 32'hF);
      chk("abort_p_clock", 32'(p_clock), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      flag = 0;
      repeat (3) begin
         @(negedge clock);
         if (done || busy) flag = 1;
      end
      chk("no_done_after_abort", 32'(flag), 32'd0);
      xfer(16'h0F0F, 3'd1, 8'd0, 4'b1101, 34);

      repeat (5) @(posedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
